// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and small operation decode helpers.
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Encoding places divide in bit 1 and signedness in bit 0.
    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring
// shift-subtract for divide, operating on magnitudes only.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_sub;

    always_comb begin
        // Multiply: {acc_hi, acc_lo} is the product register, multiplier in acc_lo.
        sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        ge      = (shifted >= {1'b0, opnd});
        rem_sub = shifted[WIDTH-1:0] - opnd;

        if (is_div) begin
            if (ge) begin
                nxt_hi = rem_sub;
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = shifted[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = sum[WIDTH:1];
            nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit with HI/LO result registers: one bit per
// cycle on operand magnitudes, then a single sign-correction cycle.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             finish;

    logic             is_div_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic             bz_r;
    logic [WIDTH-1:0] opnd_r;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    logic               sgn_a;
    logic               sgn_b;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                         input logic en);
        return en ? -v : v;
    endfunction

    assign busy  = (state != ST_IDLE);
    assign sgn_a = op_is_signed(op) & a[WIDTH-1];
    assign sgn_b = op_is_signed(op) & b[WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !cancel) begin
                    accept    = 1'b1;
                    state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_nxt = ST_IDLE;
                end else if (cnt == LAST) begin
                    state_nxt = ST_FIX;
                end
            end
            ST_FIX: begin
                finish    = !cancel;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture and iteration datapath; no reset needed, only read after acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_r <= op_is_div(op);
            neg_q_r  <= sgn_a ^ sgn_b;
            neg_r_r  <= sgn_a;
            bz_r     <= (b == '0);
            opnd_r   <= cond_neg(b, sgn_b);
            acc_hi   <= '0;
            acc_lo   <= cond_neg(a, sgn_a);
        end else if (state == ST_CALC) begin
            acc_hi   <= step_hi;
            acc_lo   <= step_lo;
        end
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div (is_div_r),
        .acc_hi (acc_hi),
        .acc_lo (acc_lo),
        .opnd   (opnd_r),
        .nxt_hi (step_hi),
        .nxt_lo (step_lo)
    );

    // Sign correction: divide by zero falls out as |a| remainder, only the quotient is forced.
    always_comb begin
        prod = cond_neg_wide({acc_hi, acc_lo}, neg_q_r);
        if (is_div_r) begin
            res_hi = cond_neg(acc_hi, neg_r_r);
            res_lo = bz_r ? '1 : cond_neg(acc_lo, neg_q_r);
        end else begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            dz   <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                cnt <= '0;
            end else if (state == ST_CALC) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (finish) begin
                hi <= res_hi;
                lo <= res_lo;
                dz <= is_div_r & bz_r;
            end else if (state == ST_IDLE) begin
                if (wr_hi) hi <= wdata;
                if (wr_lo) lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Scoreboard testbench for muldiv_iter (WIDTH=32): expected results are
// queued at launch and compared when done pulses.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run = 0;
    int failures  = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb_q[$];

    muldiv_iter #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .wr_hi  (wr_hi),
        .wr_lo  (wr_lo),
        .wdata  (wdata),
        .busy   (busy),
        .done   (done),
        .dz     (dz),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        exp_t        e;
        logic [63:0] p;
        longint      sx, sy, q, r;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        e.dz = 1'b0;
        case (o)
            2'b00: p = {32'b0, x} * {32'b0, y};
            2'b01: p = 64'(sx * sy);
            default: p = '0;
        endcase
        e.hi = p[63:32];
        e.lo = p[31:0];
        if (o[1]) begin
            if (y == 32'b0) begin
                e.lo = 32'hFFFF_FFFF;
                e.hi = x;
                e.dz = 1'b1;
            end else if (o == 2'b10) begin
                e.lo = x / y;
                e.hi = x % y;
            end else begin
                q    = sx / sy;
                r    = sx % sy;
                e.lo = q[31:0];
                e.hi = r[31:0];
            end
        end
        return e;
    endfunction

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Returns the cycle index (start cycle = 0) at which done was seen, or -1.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done !== 1'b1) n = -1;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        start  = 1'b0;
        op     = 2'b00;
        a      = '0;
        b      = '0;
        cancel = 1'b0;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        wdata  = '0;
        #1;
        tests_run++;
        if ({busy, done, dz} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl: busy/done/dz=%b required 000", {busy, done, dz});
        end
        tests_run++;
        if ({hi, lo} !== 64'h0) begin
            failures++;
            $display("FAIL reset_hilo: hi=%h lo=%h required 0/0", hi, lo);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_spec_vectors();
        logic [1:0]  vop [6] = '{2'b01, 2'b00, 2'b11, 2'b10, 2'b11, 2'b10};
        logic [31:0] va  [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'd5};
        logic [31:0] vb  [6] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'd0};
        logic [31:0] eh  [6] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001,
                                 32'h0, 32'd5};
        logic [31:0] el  [6] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h7FFF_FFFC,
                                 32'h8000_0000, 32'hFFFF_FFFF};
        logic        ed  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int   n;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            sb_q.push_back('{hi: eh[i], lo: el[i], dz: ed[i]});
            launch(vop[i], va[i], vb[i]);
            tests_run++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL spec_busy[%0d]: busy=%b required 1", i, busy);
            end
            wait_done(1, n);
            e = sb_q.pop_front();
            tests_run++;
            if (n != 34) begin
                failures++;
                $display("FAIL spec_latency[%0d]: done cycle=%0d required 34", i, n);
            end
            tests_run++;
            if ({hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
                failures++;
                $display("FAIL spec_result[%0d]: hi=%h lo=%h dz=%b required hi=%h lo=%h dz=%b",
                         i, hi, lo, dz, e.hi, e.lo, e.dz);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] edge_v [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        logic [1:0]  o;
        logic [31:0] x, y;
        int   n;
        exp_t e;
        for (int i = 0; i < 24; i++) begin
            o = 2'(i % 4);
            x = (i % 3 == 0) ? edge_v[$urandom_range(0, 5)] : $urandom;
            y = (i % 5 == 0) ? edge_v[$urandom_range(0, 5)] : $urandom >> $urandom_range(0, 28);
            sb_q.push_back(model(o, x, y));
            launch(o, x, y);
            wait_done(1, n);
            e = sb_q.pop_front();
            tests_run++;
            if (n != 34 || {hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
                failures++;
                $display("FAIL rand[%0d] op=%0d a=%h b=%h: cycle=%0d hi=%h lo=%h dz=%b required cycle=34 hi=%h lo=%h dz=%b",
                         i, o, x, y, n, hi, lo, dz, e.hi, e.lo, e.dz);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  vop [3] = '{2'b01, 2'b11, 2'b00};
        logic [31:0] va  [3] = '{32'hFFFF_FFF0, 32'd1000, 32'hDEAD_BEEF};
        logic [31:0] vb  [3] = '{32'd7, 32'hFFFF_FFFD, 32'h1234_5678};
        int   n;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            // When i > 0 this launch lands in the done cycle of the previous op.
            sb_q.push_back(model(vop[i], va[i], vb[i]));
            launch(vop[i], va[i], vb[i]);
            tests_run++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                failures++;
                $display("FAIL b2b_accept[%0d]: busy=%b done=%b required 1/0", i, busy, done);
            end
            wait_done(1, n);
            e = sb_q.pop_front();
            tests_run++;
            if (n != 34 || {hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
                failures++;
                $display("FAIL b2b[%0d]: cycle=%0d hi=%h lo=%h dz=%b required cycle=34 hi=%h lo=%h dz=%b",
                         i, n, hi, lo, dz, e.hi, e.lo, e.dz);
            end
        end
    endtask

    task automatic test_cancel();
        logic [31:0] hi0, lo0;
        int   n;
        exp_t e;
        hi0 = hi;
        lo0 = lo;
        launch(2'b11, 32'h0000_1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL cancel_pre: busy=%b in cycle 10 required 1", busy);
        end
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== hi0 || lo !== lo0) begin
            failures++;
            $display("FAIL cancel_idle: busy=%b done=%b hi=%h lo=%h required 0/0 hi=%h lo=%h",
                     busy, done, hi, lo, hi0, lo0);
        end
        sb_q.push_back(model(2'b11, 32'hFFFF_8000, 32'd9));
        launch(2'b11, 32'hFFFF_8000, 32'd9);
        wait_done(1, n);
        e = sb_q.pop_front();
        tests_run++;
        if (n != 34 || {hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
            failures++;
            $display("FAIL cancel_restart: cycle=%0d hi=%h lo=%h required cycle=34 hi=%h lo=%h",
                     n, hi, lo, e.hi, e.lo);
        end
    endtask

    task automatic test_busy_ignore();
        int   n;
        exp_t e;
        sb_q.push_back(model(2'b00, 32'h0001_0003, 32'h0002_0005));
        launch(2'b00, 32'h0001_0003, 32'h0002_0005);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'h5555_5555;
        b     = 32'h0;
        wr_hi = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_hi = 1'b0;
        wait_done(6, n);
        e = sb_q.pop_front();
        tests_run++;
        if (n != 34 || {hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
            failures++;
            $display("FAIL busy_ignore: cycle=%0d hi=%h lo=%h dz=%b required cycle=34 hi=%h lo=%h dz=%b",
                     n, hi, lo, dz, e.hi, e.lo, e.dz);
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_ignore_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_direct_write();
        logic [31:0] hi0;
        int   n;
        exp_t e;
        hi0 = hi;
        @(negedge clk);
        wr_lo = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        tests_run++;
        if (lo !== 32'h0000_1234 || hi !== hi0) begin
            failures++;
            $display("FAIL wr_lo: lo=%h hi=%h required lo=00001234 hi=%h", lo, hi, hi0);
        end
        // Write together with start: applied now, then overwritten by the result.
        sb_q.push_back(model(2'b10, 32'd100, 32'd7));
        @(negedge clk);
        wr_hi = 1'b1;
        wdata = 32'hCAFE_F00D;
        start = 1'b1;
        op    = 2'b10;
        a     = 32'd100;
        b     = 32'd7;
        @(posedge clk);
        #1;
        wr_hi = 1'b0;
        start = 1'b0;
        tests_run++;
        if (hi !== 32'hCAFE_F00D || busy !== 1'b1) begin
            failures++;
            $display("FAIL wr_hi_start: hi=%h busy=%b required hi=cafef00d busy=1", hi, busy);
        end
        wait_done(1, n);
        e = sb_q.pop_front();
        tests_run++;
        if (n != 34 || {hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
            failures++;
            $display("FAIL wr_overwrite: cycle=%0d hi=%h lo=%h required cycle=34 hi=%h lo=%h",
                     n, hi, lo, e.hi, e.lo);
        end
    endtask

    task automatic test_reset_mid();
        int   n;
        int   dones;
        exp_t e;
        sb_q.push_back(model(2'b10, 32'd5, 32'd0));
        launch(2'b10, 32'd5, 32'd0);
        wait_done(1, n);
        e = sb_q.pop_front();
        tests_run++;
        if (n != 34 || {hi, lo, dz} !== {e.hi, e.lo, e.dz}) begin
            failures++;
            $display("FAIL pre_rst_dz: cycle=%0d hi=%h lo=%h dz=%b required cycle=34 hi=%h lo=%h dz=%b",
                     n, hi, lo, dz, e.hi, e.lo, e.dz);
        end
        launch(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy, done, dz} !== 3'b000 || {hi, lo} !== 64'h0) begin
            failures++;
            $display("FAIL rst_mid: busy=%b done=%b dz=%b hi=%h lo=%h required all 0",
                     busy, done, dz, hi, lo);
        end
        @(negedge clk);
        rst   = 1'b0;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        tests_run++;
        if (dones != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_no_done: done pulses=%0d busy=%b required 0/0", dones, busy);
        end
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_random();
        test_back_to_back();
        test_cancel();
        test_busy_ignore();
        test_direct_write();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
